// File: rtl/ps2_rx_fifo_if.sv
// Read-side bundle of the PS/2 receiver: FIFO head, occupancy, pop/clear controls and error flags.
// slave = receiver (drives status/data), master = consumer (drives rd_en/clear_ovf).
interface ps2_rx_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              rd_en;
  logic              clear_ovf;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic [CNT_W-1:0]  fifo_count;
  logic              parity_err;
  logic              frame_err;
  logic              overflow;

  modport master (
    output rd_en, clear_ovf,
    input  data_out, valid, fifo_count, parity_err, frame_err, overflow
  );

  modport slave (
    input  rd_en, clear_ovf,
    output data_out, valid, fifo_count, parity_err, frame_err, overflow
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// Oversampling PS/2 device-to-host receiver with framing/timeout checks and a FWFT scan-code FIFO.
// Optional parity checking is enabled by defining PS2_PARITY_CHECK_EN.
//
//   state    | meaning
//   S_IDLE   | waiting for a start bit (data=0 on a falling edge)
//   S_DATA   | shifting in DATA_W data bits, LSB first
//   S_PARITY | sampling the parity bit
//   S_STOP   | sampling the stop bit; commit or flag the frame
module ps2_rx_fifo #(
  parameter int DATA_W         = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_rx_fifo_if.slave rx
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   clk_s, data_s, fe;

  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W:0]   shift_ext;
  logic [BIT_W-1:0]  bit_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              commit, ferr_set, perr_set, par_ok;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              ovf_q, push, pop, full;

  // Synchronisers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign fe        = clk_prev & ~clk_s;
  assign shift_ext = {data_s, shift_reg};

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    par_bit <= 1'b0;
    else if (fe && state == S_PARITY) par_bit <= data_s;
  end

  assign par_ok = ^{shift_reg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    ferr_set  = 1'b0;
    perr_set  = 1'b0;
    // Timeout only fires on a cycle without a falling edge.
    if (state != S_IDLE && !fe && tmo_cnt == '0) begin
      state_nxt = S_IDLE;
      ferr_set  = 1'b1;
    end else if (fe) begin
      unique case (state)
        S_IDLE:   if (!data_s) state_nxt = S_DATA;
        S_DATA:   if (bit_cnt == LAST_BIT) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        S_STOP: begin
          state_nxt = S_IDLE;
          if (!data_s)     ferr_set = 1'b1;
          else if (par_ok) commit   = 1'b1;
          else             perr_set = 1'b1;
        end
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Timeout is a down-counter reloaded on every edge and while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
    end else begin
      if (fe || state == S_IDLE) tmo_cnt <= TMO_LOAD;
      else if (tmo_cnt != '0)    tmo_cnt <= tmo_cnt - TMO_W'(1);

      if (fe && state == S_IDLE) bit_cnt <= '0;
      if (fe && state == S_DATA) begin
        shift_reg <= shift_ext[DATA_W:1];
        bit_cnt   <= bit_cnt + BIT_W'(1);
      end
    end
  end

  assign full = (count == FULL_CNT);
  assign pop  = rx.rd_en && (count != '0);
  assign push = commit && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A new overflow event takes priority over a simultaneous clear.
      if (commit && full && !pop) ovf_q <= 1'b1;
      else if (rx.clear_ovf)      ovf_q <= 1'b0;
    end
  end

  assign rx.valid      = (count != '0);
  assign rx.fifo_count = count;
  assign rx.data_out   = (count != '0) ? mem[rd_ptr] : '0;
  assign rx.frame_err  = ferr_set;
  assign rx.overflow   = ovf_q;
`ifdef PS2_PARITY_CHECK_EN
  assign rx.parity_err = perr_set;
`else
  assign rx.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed scenarios plus random frames against a queue model.
module tb_ps2_rx_fifo;
  localparam int DATA_W         = 8;
  localparam int FIFO_DEPTH     = 8;
  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int HALF           = 10;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic clk      = 1'b0;
  logic reset_n  = 1'b1;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_rx_fifo_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) rx();

  ps2_rx_fifo #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
    .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rx(rx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q[$];
  bit         exp_ovf  = 1'b0;
  int         exp_ferr = 0;
  int         exp_perr = 0;

  int ferr_seen = 0, perr_seen = 0, long_pulse = 0;
  bit ferr_d = 1'b0, perr_d = 1'b0;

  always @(negedge clk) begin
    if (rx.frame_err === 1'b1) begin
      if (ferr_d) long_pulse++;
      else        ferr_seen++;
    end
    if (rx.parity_err === 1'b1) begin
      if (perr_d) long_pulse++;
      else        perr_seen++;
    end
    ferr_d = (rx.frame_err === 1'b1);
    perr_d = (rx.parity_err === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    clks(HALF);
    ps2_clk = 1'b0;
    clks(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pflip, input bit stop);
    send_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
    send_bit((~^d) ^ pflip);
    send_bit(stop);
    ps2_data = 1'b1;
    clks(HALF);
  endtask

  // Reference outcome of one complete frame.
  task automatic model_frame(input logic [7:0] d, input bit pflip, input bit stop);
    if (!stop)                       exp_ferr++;
    else if (PCHK && pflip)          exp_perr++;
    else if (q.size() == FIFO_DEPTH) exp_ovf = 1'b1;
    else                             q.push_back(d);
  endtask

  task automatic frame(input logic [7:0] d, input bit pflip, input bit stop);
    send_frame(d, pflip, stop);
    model_frame(d, pflip, stop);
  endtask

  task automatic check_status(input string tag);
    check({tag, "/count"}, 32'(rx.fifo_count), 32'(q.size()));
    check({tag, "/valid"}, 32'(rx.valid), 32'(q.size() != 0));
    if (q.size() != 0) check({tag, "/head"}, 32'(rx.data_out), 32'(q[0]));
    check({tag, "/overflow"}, 32'(rx.overflow), 32'(exp_ovf));
    check({tag, "/frame_err_n"}, 32'(ferr_seen), 32'(exp_ferr));
    check({tag, "/parity_err_n"}, 32'(perr_seen), 32'(exp_perr));
    check({tag, "/pulse_width"}, 32'(long_pulse), 32'd0);
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] head;
    head = q.pop_front();
    check({tag, "/pop_valid"}, 32'(rx.valid), 32'd1);
    check({tag, "/pop_data"}, 32'(rx.data_out), 32'(head));
    rx.rd_en = 1'b1;
    clks(1);
    rx.rd_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (q.size() != 0) pop_one(tag);
    check({tag, "/drained_valid"}, 32'(rx.valid), 32'd0);
    check({tag, "/drained_count"}, 32'(rx.fifo_count), 32'd0);
  endtask

  initial begin
    logic [7:0] byte_v;
    int         tmo_lat;
    int         r;

    rx.rd_en     = 1'b0;
    rx.clear_ovf = 1'b0;
    #2 reset_n = 1'b0;
    clks(3);
    check("rst/valid", 32'(rx.valid), 32'd0);
    check("rst/count", 32'(rx.fifo_count), 32'd0);
    check("rst/data_out", 32'(rx.data_out), 32'd0);
    check("rst/parity_err", 32'(rx.parity_err), 32'd0);
    check("rst/frame_err", 32'(rx.frame_err), 32'd0);
    check("rst/overflow", 32'(rx.overflow), 32'd0);
    reset_n = 1'b1;
    clks(5);

    // 0x1C with a watched stop edge: nothing before the synchroniser delay, data shortly after.
    byte_v = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(byte_v[i]);
    send_bit(1'b0);
    ps2_data = 1'b1;
    clks(HALF);
    ps2_clk = 1'b0;
    clks(SYNC_STAGES);
    check("lat/early_valid", 32'(rx.valid), 32'd0);
    clks(2);
    check("lat/valid", 32'(rx.valid), 32'd1);
    check("lat/data", 32'(rx.data_out), 32'h1C);
    check("lat/count", 32'(rx.fifo_count), 32'd1);
    clks(HALF - SYNC_STAGES - 2);
    ps2_clk = 1'b1;
    clks(HALF);
    q.push_back(8'h1C);
    check_status("t1");
    drain("t1");

    rx.rd_en = 1'b1;
    clks(2);
    rx.rd_en = 1'b0;
    check_status("rd_empty");

    frame(8'hF0, 1'b0, 1'b1);
    frame(8'h1C, 1'b0, 1'b1);
    check_status("t2");
    pop_one("t2");
    check_status("t2b");
    drain("t2");

    frame(8'h1C, 1'b1, 1'b1);
    check_status("t3_parity");
    drain("t3");

    frame(8'h5A, 1'b0, 1'b0);
    check_status("t4_stop");

    // Start plus three data bits, then the bus goes idle.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b0;
    clks(HALF);
    ps2_clk = 1'b0;
    tmo_lat = 0;
    for (int i = 1; i <= SYNC_STAGES + TIMEOUT_CYCLES + 50; i++) begin
      @(negedge clk);
      if (i == HALF) begin
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
      end
      if (tmo_lat == 0 && rx.frame_err === 1'b1) tmo_lat = i;
    end
    check("t4/timeout_latency", 32'(tmo_lat), 32'(SYNC_STAGES + TIMEOUT_CYCLES));
    exp_ferr++;
    check_status("t4_tmo");
    frame(8'h5A, 1'b0, 1'b1);
    check_status("t4_after");
    drain("t4");

    for (int d = 1; d <= 9; d++) frame(8'(d), 1'b0, 1'b1);
    check_status("t5_full");
    rx.clear_ovf = 1'b1;
    clks(1);
    rx.clear_ovf = 1'b0;
    exp_ovf = 1'b0;
    check_status("t5_clr");
    drain("t5");

    // Reset in the middle of a frame.
    byte_v = 8'h29;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(byte_v[i]);
    clks(3);
    reset_n = 1'b0;
    clks(3);
    check("t6/valid", 32'(rx.valid), 32'd0);
    check("t6/count", 32'(rx.fifo_count), 32'd0);
    check("t6/data_out", 32'(rx.data_out), 32'd0);
    check("t6/overflow", 32'(rx.overflow), 32'd0);
    reset_n = 1'b1;
    clks(5);
    q.delete();
    exp_ovf = 1'b0;
    check_status("t6_rst");
    frame(8'h29, 1'b0, 1'b1);
    check_status("t6_next");
    drain("t6");

    for (int it = 0; it < 40; it++) begin
      byte_v = 8'($urandom);
      r = int'($urandom_range(0, 9));
      frame(byte_v, r == 1, r != 0);
      check_status("rnd");
      r = int'($urandom_range(0, 3));
      for (int k = 0; k < r && q.size() != 0; k++) pop_one("rnd");
      if ($urandom_range(0, 7) == 0) begin
        rx.clear_ovf = 1'b1;
        clks(1);
        rx.clear_ovf = 1'b0;
        exp_ovf = 1'b0;
        check("rnd/clear_ovf", 32'(rx.overflow), 32'd0);
      end
    end
    drain("rnd");
    check_status("end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
